// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the block-RAM FIFO controller.
// Defaults describe the 64x8 simple dual-port RAM it sequences.
package ram_fifo_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    localparam int SKID_N  = 2;
    localparam int SKID_CW = $clog2(SKID_N + 1);

    typedef logic [SKID_CW-1:0] skid_cnt_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry output buffer catching RAM read data one cycle after the fetch.
// Keeps the output stream bubble-free across the RAM read latency.
module ram_rd_skid
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output skid_cnt_t         cnt_o
);

    logic [DATA_W-1:0] slot_q [SKID_N];
    logic [DATA_W-1:0] slot_d [SKID_N];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    skid_cnt_t         cnt_q, cnt_d;

    always_comb begin
        slot_d   = slot_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (wr_en_i) begin
                slot_d[wr_sel_q] = wr_data_i;
                wr_sel_d         = ~wr_sel_q;
            end
            if (pop_i) begin
                rd_sel_d = ~rd_sel_q;
            end
            cnt_d = cnt_q + skid_cnt_t'(wr_en_i) - skid_cnt_t'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_N; i++) begin
                slot_q[i] <= '0;
            end
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = slot_q[rd_sel_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing a simple dual-port block RAM behind
// valid/ready streams, with pointers, occupancy and an output skid buffer.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              ram_wr_en,
    output logic              ram_wr_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0]  ptr_t;
    typedef logic [SKID_CW:0] slots_t;

    localparam ptr_t   FULL     = ptr_t'(DEPTH);
    localparam slots_t SKID_CAP = slots_t'(SKID_N);

    ptr_t      wptr_q, wptr_d;
    ptr_t      rptr_q, rptr_d;
    ptr_t      level_q, level_d;
    logic      rd_pend_q, rd_pend_d;
    skid_cnt_t skid_cnt;
    slots_t    committed;
    logic      push, pop, fetch;

    assign in_ready = (level_q != FULL);
    assign level    = level_q;
    assign push     = in_valid & in_ready & ~clr;
    assign pop      = out_valid & out_ready & ~clr;

    // Skid entries plus the read in flight, net of this cycle's pop.
    assign committed = slots_t'(skid_cnt) + slots_t'(rd_pend_q);
    assign fetch     = (rptr_q != wptr_q)
                     & (committed < SKID_CAP + slots_t'(pop))
                     & ~clr;

    assign ram_wr_en   = push;
    assign ram_wr_we   = push;
    assign ram_wr_addr = push ? wptr_q[ADDR_W-1:0] : '0;
    assign ram_wr_data = push ? in_data : '0;
    assign ram_rd_en   = fetch;
    assign ram_rd_addr = fetch ? rptr_q[ADDR_W-1:0] : '0;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        rd_pend_d = 1'b0;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            wptr_d    = wptr_q + ptr_t'(push);
            rptr_d    = rptr_q + ptr_t'(fetch);
            level_d   = level_q + ptr_t'(push) - ptr_t'(pop);
            rd_pend_d = fetch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    ram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .wr_en_i   (rd_pend_q & ~clr),
        .wr_data_i (ram_rd_data),
        .pop_i     (pop),
        .valid_o   (out_valid),
        .data_o    (out_data),
        .cnt_o     (skid_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue reference model and
// a negedge monitor scoring every handshake and RAM port access.
module tb_ram_fifo_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          ram_wr_en, ram_wr_we, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data = '0;

    ram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_we   (ram_wr_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en && ram_wr_we) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int errors = 0;
    int checks = 0;
    int npop = 0;
    int wcnt = 0;
    int rcnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_pop = '0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_hold = 1'b0;
    logic          mon_push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output side pops the scoreboard; input side pushes accepted words.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wcnt = 0;
            rcnt = 0;
            prev_hold = 1'b0;
        end else begin
            chk("level", 32'(level), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            if (exp_q.size() == 0) begin
                chk("empty_valid", 32'(out_valid), 0);
                chk("empty_rd_en", 32'(ram_rd_en), 0);
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (ram_rd_en && !clr) begin
                chk("rd_addr", 32'(ram_rd_addr), 32'(rcnt % DEPTH));
                rcnt++;
            end
            mon_push = in_valid && in_ready && !clr;
            chk("wr_en", 32'(ram_wr_en), 32'(mon_push));
            if (mon_push) begin
                chk("wr_we", 32'(ram_wr_we), 1);
                chk("wr_addr", 32'(ram_wr_addr), 32'(wcnt % DEPTH));
                chk("wr_data", 32'(ram_wr_data), 32'(in_data));
            end
            if (clr) begin
                exp_q.delete();
                wcnt = 0;
                rcnt = 0;
                prev_hold = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    chk("pop_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                    last_pop = out_data;
                    npop++;
                end
                if (mon_push) begin
                    exp_q.push_back(in_data);
                    wcnt++;
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (npop < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("pops_done", 32'(npop), 32'(target));
    endtask

    task automatic queue_ten_and_fetch();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic push_5a_first();
        int target;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        target    = npop + 1;
        step();
        in_valid = 1'b0;
        wait_pops(target, 20);
        chk("first_after_flush", 32'(last_pop), 32'h5A);
    endtask

    initial begin
        int bubbles;
        int target;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_wr_en", 32'(ram_wr_en), 0);
        chk("rst_rd_en", 32'(ram_rd_en), 0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 0);

        // Single word latency
        step();
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n_valid", 32'(out_valid), 0);
        chk("lat_n_level", 32'(level), 1);
        @(negedge clk);
        chk("lat_n1_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(out_valid), 1);
        chk("lat_n2_data", 32'(out_data), 32'hA5);
        @(negedge clk);
        chk("lat_after_pop_level", 32'(level), 0);
        step();

        // Fill to full, then drain
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_data = 8'h99;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_level", 32'(level), DEPTH);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_pops(npop + DEPTH, 200);
        repeat (3) step();

        // Streaming with no bubbles
        bubbles = 0;
        target  = npop + 200;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = 8'(i);
            @(negedge clk);
            if (i == 50) chk("stream_level", 32'(level), 3);
            if (i >= 3 && !out_valid) bubbles++;
            step();
        end
        in_valid = 1'b0;
        chk("stream_bubbles", 32'(bubbles), 0);
        wait_pops(target, 20);
        repeat (3) step();

        // Random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 2) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_pops(npop + exp_q.size(), 300);
        repeat (3) step();

        // Synchronous flush with a read in flight
        queue_ten_and_fetch();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(out_valid), 0);
        step();
        push_5a_first();
        repeat (3) step();

        // Asynchronous reset mid-stream
        queue_ten_and_fetch();
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        push_5a_first();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
